// File: rtl/ising_config.sv
// Shared configuration for the Ising DAC path: code width, GPIO field layout,
// MODE bit indices and the pulse shaper state encoding.
package ising_config;

    localparam int unsigned num_bits = 8;

    localparam int unsigned GPIO_ADDR_LSB = 0;
    localparam int unsigned GPIO_ADDR_W   = 16;
    localparam int unsigned GPIO_DATA_LSB = 16;
    localparam int unsigned GPIO_DATA_W   = 8;
    localparam int unsigned GPIO_WCLK_BIT = 24;

    localparam int unsigned MODE_BIPOLAR = 0;
    localparam int unsigned MODE_INVERT  = 1;
    localparam logic [1:0]  MODE_DEFAULT = 2'(1 << MODE_BIPOLAR);

    typedef enum logic {
        IDLE,
        ACTIVE
    } shaper_state_e;

endpackage

// File: rtl/lookup_table.sv
// Amplitude LUT with 1-cycle read latency, loaded over GPIO: ADDR_REG selects the
// entry, each DATA_REG write shifts one byte in MSB-first. Contents have no reset.
module lookup_table #(
    parameter int unsigned ADDR_REG = 0,
    parameter int unsigned DATA_REG = 1,
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [15:0]         wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [NUM_BITS-1:0] rd_idx,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [2**NUM_BITS];
    logic [NUM_BITS-1:0] waddr;
    logic [SAMPLE_W-1:0] shreg;
    logic [SAMPLE_W-1:0] shreg_next;

    // Entry is rewritten on every byte so a partially loaded value is never stale.
    assign shreg_next = (shreg << 8) | SAMPLE_W'(wr_data);

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_idx];
        if (wr_en && wr_addr == 16'(ADDR_REG)) begin
            waddr <= NUM_BITS'(wr_data);
            shreg <= '0;
        end else if (wr_en && wr_addr == 16'(DATA_REG)) begin
            shreg      <= shreg_next;
            mem[waddr] <= shreg_next;
        end
    end

endmodule

// File: rtl/dac_pulse_shaper.sv
// Builds multi-sample DAC words carrying a rectangular/bipolar pulse of LUT amplitude.
// Optional overrun counter enabled by defining DAC_PULSE_OVERRUN_CNT_EN.
module dac_pulse_shaper
    import ising_config::*;
#(
    parameter int unsigned NUM_BITS = num_bits,
    parameter int unsigned SAMPLES  = 16,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ADDR_REG = 0,
    parameter int unsigned DATA_REG = 1,
    parameter int unsigned CFG_BASE = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_BITS-1:0]          val_in,
    input  logic                         val_in_valid,
    input  logic [31:0]                  gpio_in,
    output logic [SAMPLES*SAMPLE_W-1:0]  dac_word_out,
    output logic                         busy,
    output logic [15:0]                  overrun_cnt
);

    logic [GPIO_ADDR_W-1:0] gaddr;
    logic [GPIO_DATA_W-1:0] gdata;
    logic [2:0]             wclk_sync;
    logic                   wr_stb;
    logic                   unused_gpio;

    logic [7:0]          cfg_start, cfg_len, snap_start, snap_len;
    logic [1:0]          cfg_mode, snap_mode;
    logic [SAMPLE_W-1:0] lut_data, snap_amp;
    logic                trig_q;

    shaper_state_e state, next_state;
    logic [8:0]    base, base_next;
    logic [9:0]    start10, end_pos;
    logic [8:0]    half;
    logic          last;
    logic [SAMPLES*SAMPLE_W-1:0] word;

    assign gaddr       = gpio_in[GPIO_ADDR_LSB +: GPIO_ADDR_W];
    assign gdata       = gpio_in[GPIO_DATA_LSB +: GPIO_DATA_W];
    assign wr_stb      = wclk_sync[1] & ~wclk_sync[2];
    assign unused_gpio = ^gpio_in[31:25];

    lookup_table #(
        .ADDR_REG (ADDR_REG),
        .DATA_REG (DATA_REG),
        .NUM_BITS (NUM_BITS),
        .SAMPLE_W (SAMPLE_W)
    ) u_lut (
        .clk     (clk),
        .wr_en   (wr_stb),
        .wr_addr (gaddr),
        .wr_data (gdata),
        .rd_idx  (val_in),
        .rd_data (lut_data)
    );

    assign start10 = {2'b0, snap_start};
    assign end_pos = start10 + {2'b0, snap_len};
    assign half    = ({1'b0, snap_len} + 9'd1) >> 1;
    assign last    = ({1'b0, base} + 10'(SAMPLES)) >= end_pos;
    assign busy    = (state == ACTIVE);

    function automatic logic [SAMPLE_W-1:0] shape_sample(input logic [9:0] pos);
        logic [9:0] off;
        logic       neg;
        off = pos - start10;
        neg = (snap_mode[MODE_BIPOLAR] && off >= {1'b0, half}) ^ snap_mode[MODE_INVERT];
        if (pos < start10 || pos >= end_pos)
            return '0;
        return neg ? -snap_amp : snap_amp;
    endfunction

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < SAMPLES; i++)
            word[i*SAMPLE_W +: SAMPLE_W] = shape_sample({1'b0, base} + 10'(i));
    end

    // A trigger always restarts from B=0; LEN=0 restarts straight into IDLE.
    always_comb begin
        next_state = state;
        base_next  = base;
        if (trig_q) begin
            next_state = (cfg_len != 8'd0) ? ACTIVE : IDLE;
            base_next  = '0;
        end else if (state == ACTIVE) begin
            next_state = last ? IDLE : ACTIVE;
            base_next  = last ? 9'd0 : base + 9'(SAMPLES);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            state <= next_state;
            base  <= base_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_word_out <= '0;
            trig_q       <= 1'b0;
            wclk_sync    <= '0;
            cfg_start    <= '0;
            cfg_len      <= 8'(SAMPLES);
            cfg_mode     <= MODE_DEFAULT;
            snap_start   <= '0;
            snap_len     <= '0;
            snap_mode    <= '0;
            snap_amp     <= '0;
        end else begin
            dac_word_out <= (state == ACTIVE) ? word : '0;
            trig_q       <= val_in_valid;
            wclk_sync    <= {wclk_sync[1:0], gpio_in[GPIO_WCLK_BIT]};
            if (trig_q) begin
                snap_start <= cfg_start;
                snap_len   <= cfg_len;
                snap_mode  <= cfg_mode;
                snap_amp   <= lut_data;
            end
            if (wr_stb) begin
                if (gaddr == 16'(CFG_BASE))     cfg_start <= gdata;
                if (gaddr == 16'(CFG_BASE + 1)) cfg_len   <= gdata;
                if (gaddr == 16'(CFG_BASE + 2)) cfg_mode  <= gdata[1:0];
            end
        end
    end

`ifdef DAC_PULSE_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overrun_cnt <= '0;
        else if (trig_q && state == ACTIVE && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
    end
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_dac_pulse_shaper.sv
// Directed bench for dac_pulse_shaper: default bipolar pulse, multi-word span,
// overrun restart, config writes mid-pulse, reset mid-pulse, LEN=0 and INVERT.
module tb_dac_pulse_shaper;

    localparam int W = 256;

    logic          clk;
    logic          rst;
    logic [7:0]    val_in;
    logic          val_in_valid;
    logic [31:0]   gpio_in;
    logic [W-1:0]  dac_word_out;
    logic          busy;
    logic [15:0]   overrun_cnt;

    int checks = 0;
    int errors = 0;

`ifdef DAC_PULSE_OVERRUN_CNT_EN
    localparam logic [15:0] EXP_OVR = 16'd1;
`else
    localparam logic [15:0] EXP_OVR = 16'd0;
`endif

    dac_pulse_shaper dut (
        .clk          (clk),
        .rst          (rst),
        .val_in       (val_in),
        .val_in_valid (val_in_valid),
        .gpio_in      (gpio_in),
        .dac_word_out (dac_word_out),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] fill(input int lo, input int hi, input logic [15:0] v);
        logic [W-1:0] w;
        w = '0;
        for (int i = lo; i <= hi; i++) w[i*16 +: 16] = v;
        return w;
    endfunction

    task automatic gpio_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk); gpio_in = {8'h00, d, a};
        @(negedge clk); gpio_in[24] = 1'b1;
        repeat (4) @(negedge clk);
        gpio_in[24] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic lut_write(input logic [7:0] idx, input logic [15:0] v);
        gpio_write(16'd0, idx);
        gpio_write(16'd1, v[15:8]);
        gpio_write(16'd1, v[7:0]);
    endtask

    task automatic set_cfg(input logic [7:0] s, input logic [7:0] l, input logic [7:0] m);
        gpio_write(16'd2, s);
        gpio_write(16'd3, l);
        gpio_write(16'd4, m);
    endtask

    // Returns at the negedge just after the sampling edge N.
    task automatic trig(input logic [7:0] code);
        @(negedge clk); val_in = code; val_in_valid = 1'b1;
        @(negedge clk); val_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (dac_word_out !== '0) begin errors++; $display("FAIL reset_word got %h exp 0", dac_word_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovr got %h exp 0", overrun_cnt); end
    endtask

    task automatic test_bipolar_default;
        logic [W-1:0] exp;
        exp = fill(0, 7, 16'h1234) | fill(8, 15, 16'hEDCC);
        lut_write(8'd5, 16'h1234);
        trig(8'd5);
        @(negedge clk);
        checks++; if (dac_word_out !== '0) begin errors++; $display("FAIL bip_n1 got %h exp 0", dac_word_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bip_busy_n1 got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (dac_word_out !== exp) begin errors++; $display("FAIL bip_w0 got %h exp %h", dac_word_out, exp); end
        @(negedge clk);
        checks++; if (dac_word_out !== '0) begin errors++; $display("FAIL bip_after got %h exp 0", dac_word_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bip_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_span;
        logic [W-1:0] exp [4];
        logic         exp_busy [4];
        exp = '{'0, '0, fill(4, 11, 16'h1234), '0};
        exp_busy = '{1'b1, 1'b1, 1'b0, 1'b0};
        set_cfg(8'd20, 8'd8, 8'd0);
        trig(8'd5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL span_busy_n0 got %b exp 0", busy); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (dac_word_out !== exp[k]) begin errors++; $display("FAIL span_word%0d got %h exp %h", k, dac_word_out, exp[k]); end
            checks++; if (busy !== exp_busy[k]) begin errors++; $display("FAIL span_busy%0d got %b exp %b", k, busy, exp_busy[k]); end
        end
    endtask

    task automatic test_overrun;
        logic [W-1:0] all_a, all_b, exp;
        all_a = fill(0, 15, 16'h1234);
        all_b = fill(0, 15, 16'h0100);
        lut_write(8'd7, 16'h0100);
        set_cfg(8'd0, 8'd64, 8'd0);
        trig(8'd5);
        @(negedge clk); val_in = 8'd7; val_in_valid = 1'b1;
        @(negedge clk); val_in_valid = 1'b0;
        checks++; if (dac_word_out !== all_a) begin errors++; $display("FAIL ovr_old0 got %h exp %h", dac_word_out, all_a); end
        @(negedge clk);
        checks++; if (dac_word_out !== all_a) begin errors++; $display("FAIL ovr_old1 got %h exp %h", dac_word_out, all_a); end
        checks++; if (overrun_cnt !== EXP_OVR) begin errors++; $display("FAIL ovr_cnt got %h exp %h", overrun_cnt, EXP_OVR); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = (k < 4) ? all_b : '0;
            checks++; if (dac_word_out !== exp) begin errors++; $display("FAIL ovr_restart%0d got %h exp %h", k, dac_word_out, exp); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_cfg_during_pulse;
        logic [W-1:0] all_a, exp;
        all_a = fill(0, 15, 16'h1234);
        set_cfg(8'd0, 8'd48, 8'd0);
        // LEN=4 write lands two edges after the trigger, while the pulse is active
        @(negedge clk); gpio_in = {7'h00, 1'b1, 8'd4, 16'd3}; val_in = 8'd5; val_in_valid = 1'b1;
        @(negedge clk); val_in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = (k < 3) ? all_a : '0;
            checks++; if (dac_word_out !== exp) begin errors++; $display("FAIL cfgmid_word%0d got %h exp %h", k, dac_word_out, exp); end
        end
        gpio_in[24] = 1'b0;
        repeat (3) @(negedge clk);
        trig(8'd5);
        repeat (2) @(negedge clk);
        exp = fill(0, 3, 16'h1234);
        checks++; if (dac_word_out !== exp) begin errors++; $display("FAIL cfgnext_w0 got %h exp %h", dac_word_out, exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfgnext_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_pulse;
        logic [W-1:0] inv, exp;
        inv = fill(0, 15, 16'hEDCC);
        set_cfg(8'd0, 8'd48, 8'd2);
        trig(8'd5);
        repeat (3) @(negedge clk);
        checks++; if (dac_word_out !== inv) begin errors++; $display("FAIL rstmid_w1 got %h exp %h", dac_word_out, inv); end
        rst = 1'b0;
        #1;
        checks++; if (dac_word_out !== '0) begin errors++; $display("FAIL rstmid_word got %h exp 0", dac_word_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        @(negedge clk); rst = 1'b1;
        trig(8'd5);
        repeat (2) @(negedge clk);
        exp = fill(0, 7, 16'h1234) | fill(8, 15, 16'hEDCC);
        checks++; if (dac_word_out !== exp) begin errors++; $display("FAIL rstmid_default got %h exp %h", dac_word_out, exp); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_default_busy got %b exp 0", busy); end
    endtask

    task automatic test_edge_cases;
        logic [W-1:0] exp;
        gpio_write(16'd3, 8'd0);
        trig(8'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (dac_word_out !== '0) begin errors++; $display("FAIL len0_word%0d got %h exp 0", k, dac_word_out); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy%0d got %b exp 0", k, busy); end
        end
        set_cfg(8'd0, 8'd3, 8'd3);
        trig(8'd5);
        repeat (2) @(negedge clk);
        exp = fill(0, 1, 16'hEDCC) | fill(2, 2, 16'h1234);
        checks++; if (dac_word_out !== exp) begin errors++; $display("FAIL inv_bip_w0 got %h exp %h", dac_word_out, exp); end
        @(negedge clk);
        checks++; if (dac_word_out !== '0) begin errors++; $display("FAIL inv_bip_after got %h exp 0", dac_word_out); end
    endtask

    initial begin
        rst          = 1'b1;
        val_in       = '0;
        val_in_valid = 1'b0;
        gpio_in      = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_bipolar_default;
        test_span;
        test_overrun;
        test_cfg_during_pulse;
        test_reset_mid_pulse;
        test_edge_cases;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_pulse_shaper.md
DAC_PULSE_SHAPER -- requirements
Module: dac_pulse_shaper

Interface
REQ-001 SHALL have parameter NUM_BITS, default num_bits from ising_config, giving the input code width.
REQ-002 SHALL have parameter SAMPLES, default 16, giving the number of DAC samples per output word.
REQ-003 SHALL have parameter SAMPLE_W, default 16, giving the sample width in two's complement.
REQ-004 SHALL have parameters ADDR_REG (default 0) and DATA_REG (default 1), the GPIO LUT address and data register addresses.
REQ-005 SHALL have parameter CFG_BASE, default 2, the first of three GPIO config addresses.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-008 SHALL have port val_in, input, NUM_BITS: the code used as the LUT index.
REQ-009 SHALL have port val_in_valid, input, 1 bit: the pulse trigger.
REQ-010 SHALL have port gpio_in, input, 32 bits, with fields [15:0] addr, [23:16] data and [24] w_clk.
REQ-011 SHALL have port dac_word_out, output, SAMPLES*SAMPLE_W bits, registered; sample i occupies [i*SAMPLE_W +: SAMPLE_W] and sample 0 is earliest.
REQ-012 SHALL have port busy, output, 1 bit: high while a pulse spans further words.
REQ-013 SHALL have port overrun_cnt, output, 16 bits: the count of triggers that arrived while busy.

Function
REQ-014 SHALL look up the amplitude A = LUT[val_in]; LUT latency is 1 cycle.
REQ-015 SHALL decode config writes on each synchronized w_clk rising edge:
- addr CFG_BASE writes START (8b, pulse start sample);
- addr CFG_BASE+1 writes LEN (8b, pulse length in samples);
- addr CFG_BASE+2 writes MODE (bit0 BIPOLAR, bit1 INVERT).
REQ-016 SHALL synchronize w_clk with 2 flops plus an edge detect, so each write is applied 3 clk cycles after the w_clk edge.
REQ-017 SHALL snapshot START, LEN, MODE and A at trigger; config writes during a pulse do not alter that pulse.
REQ-018 SHALL have a state machine with states IDLE and ACTIVE, and a 9-bit word base counter B that advances by SAMPLES per word.
REQ-019 SHALL, on a trigger at cycle N, place the first pulse word (B=0) on dac_word_out at cycle N+2.
REQ-020 SHALL drive sample i of the word with base B as follows:
- if p=B+i lies in [START, START+LEN-1], drive A or its negation;
- otherwise drive 0.
REQ-021 SHALL, with BIPOLAR set, drive +A for offsets p-START below ceil(LEN/2) and two's-complement -A for the remaining offsets; with BIPOLAR clear, drive +A throughout.
REQ-022 SHALL, with INVERT set, negate every nonzero sample after the BIPOLAR rule.
REQ-023 SHALL transition IDLE->ACTIVE on a trigger with LEN>0; a trigger with LEN=0 produces all-zero words and no state change.
REQ-024 SHALL transition ACTIVE->IDLE after emitting the word containing sample START+LEN-1; busy equals state==ACTIVE.
REQ-025 SHALL, on a trigger while ACTIVE, abort the current pulse, restart at B=0 with the new snapshot, and increment overrun_cnt, which saturates at 0xFFFF.
REQ-026 SHALL drive dac_word_out = 0 in every cycle that no pulse sample falls in.

Reset
REQ-027 SHALL, while rst is low, asynchronously force:
- dac_word_out=0, busy=0, overrun_cnt=0;
- state=IDLE and B=0;
- START=0, LEN=SAMPLES, MODE=BIPOLAR.
REQ-028 SHALL preserve LUT contents across reset; assertion mid-pulse truncates the pulse immediately.

Configuration
REQ-029 SHALL implement the overrun counter only when DAC_PULSE_OVERRUN_CNT_EN is defined.
REQ-030 SHALL, when DAC_PULSE_OVERRUN_CNT_EN is undefined, tie overrun_cnt to 0; the restart behaviour of REQ-025 is unchanged.

Structure
REQ-031 SHALL keep num_bits, the GPIO field positions and the MODE bit indices in package ising_config.
REQ-032 SHALL instantiate the existing lookup_table sub-module (ADDR_REG, DATA_REG, NUM_BITS, SAMPLE_W) as its only child.

Verification
REQ-033 Bench SHALL cover default-config bipolar pulse: LUT[5]=0x1234, START=0, LEN=16, trigger 5 -> at N+2 samples 0-7 are 0x1234 and samples 8-15 are 0xEDCC, then all zero.
REQ-034 Bench SHALL cover a pulse spanning words: START=20, LEN=8, MODE=0 -> word0 all zero, word1 samples 4-11 are A with the rest zero, busy high for 2 cycles.
REQ-035 Bench SHALL cover overrun restart: START=0, LEN=64, second trigger at N+2 -> pulse restarts, overrun_cnt=1, 4 nonzero words counted from the restart.
REQ-036 Bench SHALL cover config writes during a pulse: a write of LEN=4 during a LEN=48 pulse -> the current pulse keeps 48 samples and the next pulse has 4.
REQ-037 Bench SHALL cover reset mid-pulse: rst low at word 1 of a LEN=48 pulse -> dac_word_out=0 at once, busy=0, config returns to defaults.
REQ-038 Bench SHALL cover edge cases: LEN=0 trigger -> zeros and busy stays low; INVERT with BIPOLAR and LEN=3 -> samples 0x EDCC, EDCC, 1234.
